uart_rx_monitor: RTL and testbench

- Synthesizable 8N1 UART receiver: the far end of the Plasma core's uart_write serial line.
- Oversamples the line, reassembles bytes and buffers them in a small FIFO.
- Presents bytes on a valid/ready stream so a console sink, logger or loopback checker can consume them.
- Reports framing errors, false starts, overflow and line break.

---
 rtl/uart_rx_monitor.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with 2-flop input synchronizer, line-break detector and a
// first-word-fall-through byte FIFO presented as a valid/ready stream.
module uart_rx_monitor #(
    parameter int unsigned CLKS_PER_BIT    = 434,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     uart_in,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     framing_err,
    output logic                     overflow,
    output logic                     break_det,
    input  logic                     clear_err
);
    localparam int unsigned          DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam logic [15:0]          FULL_BIT   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]          HALF_BIT   = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [19:0]          BRK_TH     = 20'(10 * CLKS_PER_BIT);
    localparam logic [FIFO_DEPTH_LOG2:0] LEVEL_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 sync_q, sync_d;
    logic                       rxs;
    logic [15:0]                cnt_q, cnt_d;
    logic [2:0]                 idx_q, idx_d;
    logic [7:0]                 shift_q, shift_d;
    logic                       framing_err_q, framing_err_d;
    logic [19:0]                brk_q, brk_d;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   level_q, level_d;
    logic                       overflow_q, overflow_d;
    logic [7:0]                 mem_q [DEPTH];
    logic                       push, pop, full, wr_en;

    assign sync_d = {sync_q[0], uart_in};
    assign rxs    = sync_q[1];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        framing_err_d = 1'b0;
        push          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = HALF_BIT;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rxs) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = FULL_BIT;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = FULL_BIT;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rxs) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    framing_err_d = 1'b1;
                    state_d       = WAIT_HIGH;
                end
            end
            // Hold off until the line recovers so a break is not decoded as 0x00 bytes.
            WAIT_HIGH: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        brk_d = brk_q;
        if (rxs) begin
            brk_d = '0;
        end else if (brk_q < BRK_TH) begin
            brk_d = brk_q + 20'd1;
        end
    end

    assign break_det = !rxs && (brk_q >= BRK_TH);

    always_comb begin
        full       = (level_q == LEVEL_FULL);
        pop        = (level_q != '0) && rx_ready;
        wr_en      = push && (!full || pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d    = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!wr_en && pop) begin
            level_d = level_q - 1'b1;
        end
        // A new overflow in the same cycle as clear_err keeps the flag set.
        overflow_d = (overflow_q && !clear_err) || (push && full && !pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            sync_q        <= 2'b11;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            framing_err_q <= 1'b0;
            brk_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            framing_err_q <= framing_err_d;
            brk_q         <= brk_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_data     = (level_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign rx_valid    = (level_q != '0);
    assign fifo_level  = level_q;
    assign framing_err = framing_err_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor: directed frame sequences plus a
// randomized frame stream scored against an expected-byte queue.
module tb_uart_rx_monitor;
    localparam int CPB   = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          uart_in;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [DL:0]   fifo_level;
    logic          framing_err;
    logic          overflow;
    logic          break_det;
    logic          clear_err;

    int            n_vec = 0;
    int            n_err = 0;
    int            fe_cnt = 0;
    int            brk_seen = 0;
    logic          mon_en = 1'b0;
    logic          rnd_run = 1'b0;
    logic [7:0]    exp_q [$];
    logic [7:0]    mon_exp;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [DL:0] exp_level;
    } vec_t;
    vec_t tbl [4];

    uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset(reset), .uart_in(uart_in), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_level(fifo_level),
        .framing_err(framing_err), .overflow(overflow), .break_det(break_det),
        .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        uart_in = v;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
        drive_bit(stop, CPB);
    endtask

    task automatic expect_one(input string name, input logic [7:0] b);
        check({name, "_level"}, 32'(fifo_level), 1);
        check({name, "_data"}, 32'(rx_data), 32'(b));
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check({name, "_drained"}, 32'(rx_valid), 0);
    endtask

    always @(negedge clk) begin
        if (framing_err) fe_cnt++;
        if (break_det) brk_seen++;
        if (mon_en && rx_valid && rx_ready) begin
            check("rnd_queue_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("rnd_byte", 32'(rx_data), 32'(mon_exp));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, brk0, first, highs, n_bad;
        logic [7:0] got, b;

        tbl[0] = '{8'h00, 1'b1, 5'd1};
        tbl[1] = '{8'hFF, 1'b1, 5'd2};
        tbl[2] = '{8'hA5, 1'b1, 5'd3};
        tbl[3] = '{8'h3C, 1'b1, 5'd4};

        reset = 1'b0; uart_in = 1'b1; rx_ready = 1'b0; clear_err = 1'b0;
        repeat (3) tick();
        check("rst_data", 32'(rx_data), 0);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_fe", 32'(framing_err), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_brk", 32'(break_det), 0);
        reset = 1'b1;
        repeat (4) tick();

        // Single-byte latency and one-cycle valid with rx_ready held high.
        rx_ready = 1'b1; fe0 = fe_cnt; first = 0; highs = 0; got = '0;
        fork
            send_frame(8'h55, 1'b1);
        join_none
        for (int k = 1; k <= 90; k++) begin
            tick();
            if (rx_valid) begin
                highs++;
                if (first == 0) begin
                    first = k;
                    got   = rx_data;
                end
            end
        end
        check("lat_cycles", 32'(first), 79);
        check("lat_width", 32'(highs), 1);
        check("lat_data", 32'(got), 32'h55);
        check("lat_no_fe", 32'(fe_cnt - fe0), 0);
        check("lat_empty_data", 32'(rx_data), 0);

        // Back-to-back frames buffered, then drained in order.
        rx_ready = 1'b0; fe0 = fe_cnt; brk0 = brk_seen;
        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].data, tbl[i].stop);
            check("tbl_level", 32'(fifo_level), 32'(tbl[i].exp_level));
        end
        check("tbl_no_fe", 32'(fe_cnt - fe0), 0);
        check("tbl_no_brk", 32'(brk_seen - brk0), 0);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("tbl_valid", 32'(rx_valid), 1);
            check("tbl_drain", 32'(rx_data), 32'(tbl[i].data));
            tick();
        end
        check("tbl_valid_fall", 32'(rx_valid), 0);
        rx_ready = 1'b0;

        // Overflow: 17 bytes into a 16-entry FIFO.
        for (int i = 1; i <= DEPTH + 1; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1);
        end
        check("ovf_level", 32'(fifo_level), DEPTH);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_head", 32'(rx_data), 1);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        check("ovf_clear", 32'(overflow), 0);
        check("ovf_level_kept", 32'(fifo_level), DEPTH);
        rx_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            check("ovf_drain", 32'(rx_data), 32'(i));
            tick();
        end
        check("ovf_no_17th", 32'(rx_valid), 0);
        rx_ready = 1'b0;

        // Framing error followed by a long low line (break).
        fe0 = fe_cnt;
        send_frame(8'h7E, 1'b0);
        drive_bit(1'b0, 12 * CPB);
        check("fe_pulse", 32'(fe_cnt - fe0), 1);
        check("fe_no_byte", 32'(fifo_level), 0);
        check("brk_set", 32'(break_det), 1);
        uart_in = 1'b1; tick();
        check("brk_hold_sync", 32'(break_det), 1);
        tick();
        check("brk_clear", 32'(break_det), 0);
        drive_bit(1'b1, CPB);
        send_frame(8'h42, 1'b1);
        expect_one("fe_next", 8'h42);

        // False start: 2-cycle glitch.
        fe0 = fe_cnt;
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 3 * CPB);
        check("glitch_no_byte", 32'(fifo_level), 0);
        check("glitch_no_fe", 32'(fe_cnt - fe0), 0);
        send_frame(8'h99, 1'b1);
        expect_one("glitch_next", 8'h99);

        // Reset during data bit 4 of 0xC3, released while the line is high in bit 6.
        send_frame(8'h11, 1'b1);
        check("rmf_pre_level", 32'(fifo_level), 1);
        fe0 = fe_cnt; b = 8'hC3;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
        drive_bit(b[4], 3);
        reset = 1'b0;
        tick();
        check("rmf_level", 32'(fifo_level), 0);
        check("rmf_valid", 32'(rx_valid), 0);
        check("rmf_data", 32'(rx_data), 0);
        repeat (CPB - 4) tick();
        drive_bit(b[5], CPB);
        drive_bit(b[6], 2);
        reset = 1'b1;
        repeat (CPB - 2) tick();
        drive_bit(b[7], CPB);
        drive_bit(1'b1, 2 * CPB);
        check("rmf_no_byte", 32'(fifo_level), 0);
        check("rmf_no_fe", 32'(fe_cnt - fe0), 0);
        send_frame(8'h5A, 1'b1);
        expect_one("rmf_next", 8'h5A);

        // Random frame stream with random consumer back-pressure.
        fe0 = fe_cnt; n_bad = 0;
        mon_en = 1'b1; rnd_run = 1'b1;
        fork
            while (rnd_run) begin
                tick();
                rx_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int f = 0; f < 40; f++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                n_bad++;
                send_frame(b, 1'b0);
                drive_bit(1'b1, CPB);
            end else begin
                exp_q.push_back(b);
                send_frame(b, 1'b1);
            end
            drive_bit(1'b1, CPB * int'($urandom_range(0, 2)));
        end
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
        rnd_run = 1'b0;
        repeat (3) tick();
        mon_en = 1'b0;
        rx_ready = 1'b0;
        tick();
        check("rnd_all_received", 32'(exp_q.size()), 0);
        check("rnd_empty", 32'(rx_valid), 0);
        check("rnd_fe_count", 32'(fe_cnt - fe0), 32'(n_bad));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
